sequence_checker: RTL and testbench
===================================

Name: sequence_checker

Overview:
- Pattern store and player-input judge for the Simon Says game.
- Sits beside the game FSM: it appends a random colour step each round and replays the stored pattern for the LED/pulse stage.
- It judges the player's switch inputs against the stored pattern and drives the FSM's `result` input.
- All handshakes are single-cycle strobes from the FSM.

Parameters:
- MAX_ROUNDS, 64, capacity of the pattern store (steps).
- LFSR_W, 16, width of the free-running random generator.
- LFSR_SEED, 16'hACE1, LFSR reset value (non-zero).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- new_game  input  1  strobe: clear pattern, indices and verdict.
- add_step  input  1  strobe: append LFSR[1:0] as next colour.
- play_start  input  1  strobe: playback index to 0.
- play_next  input  1  strobe: advance playback index.
- play_color  output  4  one-hot colour at playback index; 0 when index >= seq_len.
- play_last  output  1  playback index == seq_len-1.
- check_start  input  1  strobe: begin judging from step 0.
- player_input  input  4  switch bank, one bit per colour.
- result  output  1  last verdict (1 = correct press).
- result_valid  output  1  one-cycle pulse when result updates.
- round_done  output  1  one-cycle pulse when all seq_len steps are matched.
- seq_len  output  7  stored steps (0..MAX_ROUNDS).
- seq_full  output  1  seq_len == MAX_ROUNDS.

Behaviour:
- Reset:
  - seq_len, play/chk indices, result, result_valid, round_done = 0.
  - Checker state = IDLE; LFSR = LFSR_SEED.
  - Store contents are don't-care.
- LFSR: Galois, advances every cycle including IDLE. It is not cleared by new_game, and is never 0.
- new_game has top priority: same-cycle add_step, play_* and check_start are ignored. The checker returns to IDLE.
- add_step:
  - Writes LFSR[1:0] at index seq_len; seq_len increments the next cycle.
  - Ignored when seq_full.
  - Colour map: 0 = bit0, 1 = bit1, 2 = bit2, 3 = bit3 of player_input.
- Playback:
  - play_start beats play_next when both are asserted.
  - play_next saturates at seq_len.
  - play_color and play_last are combinational from the registered index and the store.
- Checker FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE.
  - IDLE + check_start:
    - seq_len == 0: round_done pulses next cycle, no result_valid, stay IDLE.
    - Otherwise: chk_idx = 0, go to WAIT_PRESS.
  - WAIT_PRESS, player_input != 0 sampled in cycle N:
    - In N+1: result = (player_input == onehot(store[chk_idx])) and result_valid = 1.
    - Multi-hot input is always a mismatch.
    - Match: go to WAIT_RELEASE.
    - Mismatch: go to IDLE (game over is handled by the FSM).
  - WAIT_RELEASE, player_input == 0:
    - If chk_idx == seq_len-1: round_done pulses, go to IDLE.
    - Else: chk_idx++, go to WAIT_PRESS.
    - Input held non-zero keeps the state; no repeat verdict.
  - check_start outside IDLE restarts at step 0 and sets state to WAIT_PRESS.
- add_step while the checker is active is permitted; seq_len updates, and the current check uses the new length.
- result holds its value between verdicts; cleared only by reset or new_game.
- Reset asserted mid-check: all outputs return to reset values on the next edge.

Decomposition:
- simon_pkg holds:
  - colour_t (2-bit enum RED/GREEN/BLUE/YELLOW).
  - chk_state_t enum.
  - LFSR tap constant 16'hB400.
  - onehot function, colour_t to 4-bit.
- Sub-module lfsr_rng (parameters LFSR_W, LFSR_SEED, taps): free-running, output bus only.
- Pattern store is an inferred register array inside sequence_checker.

Test Plan:
- Reset, then 3 add_step strobes at known LFSR states → seq_len = 3. Playback via play_start / play_next ×3 → play_color matches the bench LFSR model; play_last is high on the third step only.
- check_start, then the correct one-hot per step with release between steps → three result_valid pulses with result = 1, round_done one cycle after the final release.
- Step 2 given wrong colour, e.g. 4'b0011 or an incorrect single bit → result_valid with result = 0 at N+1; checker IDLE; no round_done.
- Press held for 6 cycles → exactly one result_valid; next step not judged until input = 0.
- 64 add_steps, then a 65th → seq_full = 1, seq_len stays 64. new_game + add_step in the same cycle → seq_len = 0.
- check_start with seq_len = 0 → round_done next cycle, no result_valid. Reset mid-WAIT_RELEASE → all outputs 0, state IDLE.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says pattern checker.
package simon_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2
  } chk_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Colour to switch-bank bit: RED=bit0 .. YELLOW=bit3.
  function automatic logic [3:0] onehot(input colour_t c);
    logic [3:0] v;
    v = 4'b0000;
    case (c)
      RED:     v = 4'b0001;
      GREEN:   v = 4'b0010;
      BLUE:    v = 4'b0100;
      YELLOW:  v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/lfsr_rng.sv
// Free-running Galois LFSR; exposes only its low OUT_W bits.
module lfsr_rng #(
  parameter int unsigned        LFSR_W    = 16,
  parameter int unsigned        OUT_W     = 2,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1,
  parameter logic [LFSR_W-1:0]  TAPS      = 16'hB400
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] rnd
);

  logic [LFSR_W-1:0] lfsr_q;

  // Right-shifting Galois step; a non-zero seed keeps the register non-zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (lfsr_q[0]) begin
      lfsr_q <= (lfsr_q >> 1) ^ TAPS;
    end else begin
      lfsr_q <= lfsr_q >> 1;
    end
  end

  assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/sequence_checker.sv
// Simon Says pattern store, playback pointer and player-input judge.
module sequence_checker
  import simon_pkg::*;
#(
  parameter int unsigned       MAX_ROUNDS = 64,
  parameter int unsigned       LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       add_step,
  input  logic       play_start,
  input  logic       play_next,
  output logic [3:0] play_color,
  output logic       play_last,
  input  logic       check_start,
  input  logic [3:0] player_input,
  output logic       result,
  output logic       result_valid,
  output logic       round_done,
  output logic [6:0] seq_len,
  output logic       seq_full
);

  localparam int unsigned IDX_W = $clog2(MAX_ROUNDS);
  localparam int unsigned LEN_W = 7;

  logic [1:0]       rnd;
  colour_t          store [MAX_ROUNDS];
  logic [LEN_W-1:0] play_idx;
  logic [IDX_W-1:0] chk_idx, chk_idx_nxt;
  chk_state_t       state, state_nxt;
  logic             result_nxt, result_valid_nxt, round_done_nxt;
  logic             add_ok;
  logic             chk_last;

  lfsr_rng #(
    .LFSR_W    (LFSR_W),
    .OUT_W     (2),
    .LFSR_SEED (LFSR_SEED),
    .TAPS      (LFSR_W'(LFSR_TAPS))
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .rnd   (rnd)
  );

  assign add_ok   = add_step && !new_game && !seq_full;
  assign chk_last = (LEN_W'(chk_idx) == seq_len - LEN_W'(1));

  // Pattern store write; contents need no reset since seq_len gates every read.
  always_ff @(posedge clk) begin
    if (add_ok) begin
      store[seq_len[IDX_W-1:0]] <= colour_t'(rnd);
    end
  end

  // Stored length and full flag.
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      seq_len  <= '0;
      seq_full <= 1'b0;
    end else if (add_ok) begin
      seq_len  <= seq_len + LEN_W'(1);
      seq_full <= (seq_len == LEN_W'(MAX_ROUNDS - 1));
    end
  end

  // Playback pointer: start wins over next, next saturates at seq_len.
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      play_idx <= '0;
    end else if (play_start) begin
      play_idx <= '0;
    end else if (play_next && (play_idx < seq_len)) begin
      play_idx <= play_idx + LEN_W'(1);
    end
  end

  // Playback outputs decoded straight from the pointer and store.
  always_comb begin
    play_color = 4'b0000;
    if (play_idx < seq_len) begin
      play_color = onehot(store[play_idx[IDX_W-1:0]]);
    end
    play_last = (seq_len != '0) && (play_idx == seq_len - LEN_W'(1));
  end

  // Checker state and registered verdict outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      chk_idx      <= '0;
      result       <= 1'b0;
      result_valid <= 1'b0;
      round_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      chk_idx      <= chk_idx_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      round_done   <= round_done_nxt;
    end
  end

  // Checker next-state: new_game over check_start over normal judging.
  always_comb begin
    state_nxt        = state;
    chk_idx_nxt      = chk_idx;
    result_nxt       = result;
    result_valid_nxt = 1'b0;
    round_done_nxt   = 1'b0;
    if (new_game) begin
      state_nxt   = IDLE;
      chk_idx_nxt = '0;
      result_nxt  = 1'b0;
    end else if (check_start) begin
      if ((state == IDLE) && (seq_len == '0)) begin
        round_done_nxt = 1'b1;
      end else begin
        chk_idx_nxt = '0;
        state_nxt   = WAIT_PRESS;
      end
    end else begin
      case (state)
        WAIT_PRESS: begin
          if (player_input != 4'b0000) begin
            result_valid_nxt = 1'b1;
            result_nxt       = (player_input == onehot(store[chk_idx]));
            state_nxt        = result_nxt ? WAIT_RELEASE : IDLE;
          end
        end
        WAIT_RELEASE: begin
          if (player_input == 4'b0000) begin
            if (chk_last) begin
              round_done_nxt = 1'b1;
              state_nxt      = IDLE;
            end else begin
              chk_idx_nxt = chk_idx + IDX_W'(1);
              state_nxt   = WAIT_PRESS;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_checker.sv
// Scoreboard bench for sequence_checker: stimulus queues expected events, monitor pops them.
module tb_sequence_checker;

  logic       clk = 1'b0;
  logic       reset, new_game, add_step, play_start, play_next, check_start;
  logic [3:0] player_input;
  logic [3:0] play_color;
  logic       play_last, result, result_valid, round_done, seq_full;
  logic [6:0] seq_len;

  always #5 clk = ~clk;

  sequence_checker dut (
    .clk          (clk),
    .reset        (reset),
    .new_game     (new_game),
    .add_step     (add_step),
    .play_start   (play_start),
    .play_next    (play_next),
    .play_color   (play_color),
    .play_last    (play_last),
    .check_start  (check_start),
    .player_input (player_input),
    .result       (result),
    .result_valid (result_valid),
    .round_done   (round_done),
    .seq_len      (seq_len),
    .seq_full     (seq_full)
  );

  // Reference LFSR and expected pattern, tracked from the driven strobes.
  logic [15:0] m_lfsr;
  logic [1:0]  m_store [64];
  int          m_len;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_lfsr <= 16'hACE1;
      m_len  <= 0;
    end else begin
      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      if (new_game) begin
        m_len <= 0;
      end else if (add_step && m_len < 64) begin
        m_store[m_len] <= m_lfsr[1:0];
        m_len          <= m_len + 1;
      end
    end
  end

  function automatic logic [3:0] oh(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  typedef struct {
    int   kind;   // 0 = verdict, 1 = round_done
    int   at;
    logic res;
  } ev_t;

  ev_t q[$];
  int  n_pass = 0;
  int  n_total = 0;
  bit  stim_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] v, input int hold, input bit exp_ev, input logic exp_res);
    player_input = v;
    if (exp_ev) q.push_back('{kind: 0, at: cyc + 1, res: exp_res});
    repeat (hold) tick();
  endtask

  task automatic release_in(input bit exp_done);
    player_input = 4'b0000;
    if (exp_done) q.push_back('{kind: 1, at: cyc + 1, res: 1'b0});
    tick();
  endtask

  task automatic pulse_check_start(input bit exp_done);
    check_start = 1'b1;
    if (exp_done) q.push_back('{kind: 1, at: cyc + 1, res: 1'b0});
    tick();
    check_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_seq_len"},      32'(seq_len),      32'd0);
    check({tag, "_seq_full"},     32'(seq_full),     32'd0);
    check({tag, "_result"},       32'(result),       32'd0);
    check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_round_done"},   32'(round_done),   32'd0);
    check({tag, "_play_color"},   32'(play_color),   32'd0);
    check({tag, "_play_last"},    32'(play_last),    32'd0);
  endtask

  // Monitor: every DUT event must match the head of the queue, in the right cycle.
  task automatic monitor();
    ev_t e;
    while (!stim_done) begin
      @(negedge clk);
      if (q.size() > 0 && q[0].at < cyc) begin
        e = q.pop_front();
        n_total++;
        $display("FAIL missed_event: kind %0d due at cycle %0d, not seen by cycle %0d", e.kind, e.at, cyc);
      end
      if (result_valid || round_done) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_event at cycle %0d: result_valid=%0b round_done=%0b, required none",
                   cyc, result_valid, round_done);
        end else begin
          e = q.pop_front();
          check("event_cycle", 32'(cyc), 32'(e.at));
          check("event_kind", 32'(round_done), 32'(e.kind));
          if (e.kind == 0) check("verdict", 32'(result), 32'(e.res));
        end
      end
    end
  endtask

  task automatic stimulus();
    logic [3:0] v;
    reset = 1'b1; new_game = 1'b0; add_step = 1'b0; play_start = 1'b0;
    play_next = 1'b0; check_start = 1'b0; player_input = 4'b0000;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_all_zero("reset");

    // Three steps, then playback with saturation and start-over-next priority.
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      add_step = 1'b1; tick(); add_step = 1'b0; tick();
    end
    check("seq_len_3", 32'(seq_len), 32'd3);
    play_start = 1'b1; tick(); play_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("play_color_%0d", i), 32'(play_color), (i < 3) ? 32'(oh(m_store[i])) : 32'd0);
      check($sformatf("play_last_%0d", i), 32'(play_last), (i == 2) ? 32'd1 : 32'd0);
      play_next = 1'b1; tick(); play_next = 1'b0;
    end
    check("play_sat_color", 32'(play_color), 32'd0);
    play_start = 1'b1; play_next = 1'b1; tick(); play_start = 1'b0; play_next = 1'b0;
    check("play_restart_color", 32'(play_color), 32'(oh(m_store[0])));
    check("play_restart_last", 32'(play_last), 32'd0);

    // Correct full round.
    pulse_check_start(1'b0);
    for (int i = 0; i < 3; i++) begin
      press(oh(m_store[i]), 1, 1'b1, 1'b1);
      release_in(i == 2);
    end
    repeat (2) tick();

    // Long hold, change while held, then multi-hot at step 2, then checker idle.
    pulse_check_start(1'b0);
    press(oh(m_store[0]), 6, 1'b1, 1'b1);
    press(4'b1111, 2, 1'b0, 1'b0);
    release_in(1'b0);
    press(oh(m_store[1]), 1, 1'b1, 1'b1);
    release_in(1'b0);
    press(4'b0011, 1, 1'b1, 1'b0);
    release_in(1'b0);
    press(oh(m_store[2]), 2, 1'b0, 1'b0);
    release_in(1'b0);
    check("result_hold_0", 32'(result), 32'd0);

    // Restart mid-check, then a wrong single colour at step 1.
    pulse_check_start(1'b0);
    press(oh(m_store[0]), 1, 1'b1, 1'b1);
    release_in(1'b0);
    pulse_check_start(1'b0);
    press(oh(m_store[0]), 1, 1'b1, 1'b1);
    release_in(1'b0);
    v = oh(m_store[1]);
    press({v[2:0], v[3]}, 1, 1'b1, 1'b0);
    release_in(1'b0);
    check("result_after_wrong", 32'(result), 32'd0);

    // new_game clears; empty check gives round_done only.
    press(oh(m_store[0]), 0, 1'b0, 1'b0);
    pulse_check_start(1'b0);
    press(oh(m_store[0]), 2, 1'b1, 1'b1);
    release_in(1'b0);
    check("result_before_new_game", 32'(result), 32'd1);
    new_game = 1'b1; tick(); new_game = 1'b0;
    check("new_game_seq_len", 32'(seq_len), 32'd0);
    check("new_game_result", 32'(result), 32'd0);
    pulse_check_start(1'b1);
    tick();

    // Fill to capacity and try one more; last slot plays back.
    add_step = 1'b1; repeat (65) tick(); add_step = 1'b0;
    check("full_seq_len", 32'(seq_len), 32'd64);
    check("full_flag", 32'(seq_full), 32'd1);
    play_start = 1'b1; tick(); play_start = 1'b0;
    play_next = 1'b1; repeat (63) tick(); play_next = 1'b0;
    check("play_color_63", 32'(play_color), 32'(oh(m_store[63])));
    check("play_last_63", 32'(play_last), 32'd1);
    new_game = 1'b1; add_step = 1'b1; tick(); new_game = 1'b0; add_step = 1'b0;
    check("new_game_add_seq_len", 32'(seq_len), 32'd0);
    check("new_game_add_full", 32'(seq_full), 32'd0);

    // Reset while waiting for release.
    add_step = 1'b1; repeat (2) tick(); add_step = 1'b0;
    pulse_check_start(1'b0);
    press(oh(m_store[0]), 2, 1'b1, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    check_all_zero("mid_reset");
    release_in(1'b0);
    press(4'b0001, 2, 1'b0, 1'b0);
    release_in(1'b0);
    pulse_check_start(1'b1);

    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    tick();
    stim_done = 1'b1;
  endtask

  initial begin
    fork
      stimulus();
      monitor();
    join
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      n_total++;
      $display("FAIL pending_event: kind %0d due at cycle %0d never seen", e.kind, e.at);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
